// File: rtl/wb_arbiter_rr.sv
// N-master to 1-slave Wishbone arbiter: round-robin or fixed priority, grant held for the whole cyc.
// Optional slave-response watchdog enabled by defining WB_ARBITER_RR_WATCHDOG_EN.
module wb_arbiter_rr #(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int num_masters = 4,
  parameter int PRIO_MODE   = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [num_masters*aw-1:0]   wbm_adr_i,
  input  logic [num_masters*dw-1:0]   wbm_dat_i,
  input  logic [num_masters*dw/8-1:0] wbm_sel_i,
  input  logic [num_masters-1:0]      wbm_we_i,
  input  logic [num_masters-1:0]      wbm_cyc_i,
  input  logic [num_masters-1:0]      wbm_stb_i,
  input  logic [num_masters*3-1:0]    wbm_cti_i,
  input  logic [num_masters*2-1:0]    wbm_bte_i,
  output logic [num_masters*dw-1:0]   wbm_dat_o,
  output logic [num_masters-1:0]      wbm_ack_o,
  output logic [num_masters-1:0]      wbm_err_o,
  output logic [num_masters-1:0]      wbm_rty_o,
  output logic [aw-1:0]               wbs_adr_o,
  output logic [dw-1:0]               wbs_dat_o,
  output logic [dw/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  input  logic [dw-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [num_masters-1:0]      grant_o
);

  localparam int unsigned NM = num_masters;
  localparam int unsigned IW = $clog2(num_masters);

  if (num_masters < 2 || num_masters > 16 || TIMEOUT < 2 || (dw % 8) != 0) begin : g_param_check
    $error("wb_arbiter_rr: unsupported parameter set");
  end

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t          state_q;
  logic [NM-1:0]   grant_q;
  logic [IW-1:0]   last_q;

  logic [NM-1:0]   arb_req;
  logic            win_found;
  logic [NM-1:0]   grant_d;
  logic [IW-1:0]   last_d;
  int unsigned     cand;

  logic            g_cyc;
  logic            g_stb;
  logic            resp;
  logic            release_grant;
  logic            wd_fire;

  // The granted master's own cyc is already low at a release point, so masking it out
  // only matters for the watchdog release, where it must not win again.
  always_comb begin
    arb_req   = (state_q == IDLE) ? wbm_cyc_i : (wbm_cyc_i & ~grant_q);
    win_found = 1'b0;
    grant_d   = '0;
    last_d    = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NM; k++) begin
      if (PRIO_MODE != 0) cand = k;
      else                cand = (32'(last_q) + k + 1) % NM;
      if (!win_found && arb_req[cand]) begin
        win_found     = 1'b1;
        grant_d       = '0;
        grant_d[cand] = 1'b1;
        last_d        = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (grant_q[i]) begin
        wbs_adr_o = wbm_adr_i[i*aw +: aw];
        wbs_dat_o = wbm_dat_i[i*dw +: dw];
        wbs_sel_o = wbm_sel_i[i*(dw/8) +: (dw/8)];
        wbs_we_o  = wbm_we_i[i];
        wbs_cti_o = wbm_cti_i[i*3 +: 3];
        wbs_bte_o = wbm_bte_i[i*2 +: 2];
      end
    end
  end

  assign g_cyc         = |(grant_q & wbm_cyc_i);
  assign g_stb         = |(grant_q & wbm_stb_i);
  assign resp          = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign release_grant = ~g_cyc | wd_fire;

  assign wbs_cyc_o = g_cyc & ~wd_fire;
  assign wbs_stb_o = g_cyc & g_stb & ~wd_fire;
  assign wbm_dat_o = {NM{wbs_dat_i}};
  assign wbm_ack_o = grant_q & {NM{wbs_ack_i}};
  assign wbm_err_o = grant_q & {NM{wbs_err_i | wd_fire}};
  assign wbm_rty_o = grant_q & {NM{wbs_rty_i}};
  assign grant_o   = grant_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NM - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= GRANTED;
            grant_q <= grant_d;
            last_q  <= last_d;
          end
        end
        GRANTED: begin
          if (release_grant) begin
            if (win_found) begin
              grant_q <= grant_d;
              last_q  <= last_d;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

`ifdef WB_ARBITER_RR_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;

  assign wd_fire = (state_q == GRANTED) && (wd_q == WD_LIMIT);

  always_comb begin
    wd_d = wd_q;
    if (state_q == IDLE || release_grant || resp) wd_d = '0;
    else if (wbs_stb_o)                           wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Self-checking bench for wb_arbiter_rr: directed sequences, a fixed-priority vector table,
// and randomized traffic compared against an arithmetic round-robin model.
module tb_wb_arbiter_rr;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat;
  logic [N*DW/8-1:0] m_sel;
  logic [N-1:0]      m_we, m_cyc, m_stb, p_cyc;
  logic [N*3-1:0]    m_cti;
  logic [N*2-1:0]    m_bte;
  logic [DW-1:0]     s_dat;
  logic              s_ack, s_err, s_rty;

  logic [N*DW-1:0]   wbm_dat_o, p_dat_o;
  logic [N-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [N-1:0]      p_ack, p_err, p_rty, p_grant;
  logic [AW-1:0]     wbs_adr_o, p_adr;
  logic [DW-1:0]     wbs_dat_o, p_dat;
  logic [DW/8-1:0]   wbs_sel_o, p_sel;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o, p_we, p_cyc_o, p_stb_o;
  logic [2:0]        wbs_cti_o, p_cti;
  logic [1:0]        wbs_bte_o, p_bte;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_rr #(.dw(DW), .aw(AW), .num_masters(N), .PRIO_MODE(0), .TIMEOUT(16)) u_rr (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant_o)
  );

  wb_arbiter_rr #(.dw(DW), .aw(AW), .num_masters(N), .PRIO_MODE(1), .TIMEOUT(16)) u_fix (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(p_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(p_dat_o), .wbm_ack_o(p_ack), .wbm_err_o(p_err), .wbm_rty_o(p_rty),
    .wbs_adr_o(p_adr), .wbs_dat_o(p_dat), .wbs_sel_o(p_sel), .wbs_we_o(p_we),
    .wbs_cti_o(p_cti), .wbs_bte_o(p_bte), .wbs_cyc_o(p_cyc_o), .wbs_stb_o(p_stb_o),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(p_grant)
  );

  typedef struct {
    logic [N-1:0] cyc;
    logic [N-1:0] exp_grant;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Round-robin winner: the requester at the smallest forward distance past the last grant.
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    int best, bd, d;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        d = (i - last - 1 + 2 * N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic pulse_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t tbl[$];
    int   g, last, nxt, since_resp;
    logic [N-1:0] req;

    rst   = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; p_cyc = '0;
    m_cti = '0; m_bte = '0; m_sel = '1;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_adr[i*AW +: AW] = 32'h1000_0000 + 32'(i) * 32'h100;
      m_dat[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    end

    // Reset state
    tick(); tick();
    chk("reset_grant", 64'(grant_o), 64'd0);
    chk("reset_cyc", 64'(wbs_cyc_o), 64'd0);
    chk("reset_ack", 64'(wbm_ack_o), 64'd0);
    chk("reset_fix_grant", 64'(p_grant), 64'd0);
    rst = 1'b0;

    // Master 0 single read, slave acks two cycles after grant
    m_cyc = 4'b0001; m_stb = 4'b0001;
    settle();
    chk("single_cyc_latency", 64'(wbs_cyc_o), 64'd0);
    tick();
    chk("single_grant", 64'(grant_o), 64'b0001);
    chk("single_cyc", 64'(wbs_cyc_o), 64'd1);
    chk("single_adr", 64'(wbs_adr_o), 64'h1000_0000);
    tick();
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    settle();
    chk("single_ack", 64'(wbm_ack_o), 64'b0001);
    chk("single_rdata", 64'(wbm_dat_o[DW-1:0]), 64'hDEAD_BEEF);
    tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    settle();
    chk("single_cyc_drop", 64'(wbs_cyc_o), 64'd0);
    tick();
    chk("single_idle", 64'(grant_o), 64'd0);

    // Round-robin rotation with all four masters requesting
    pulse_reset();
    m_cyc = 4'b1111; m_stb = 4'b1111;
    tick();
    for (int t = 0; t < 32; t++) begin
      g = t % N;
      chk("rr_order", 64'(grant_o), 64'(onehot(g)));
      s_ack = 1'b1;
      settle();
      chk("rr_ack", 64'(wbm_ack_o), 64'(onehot(g)));
      tick();
      s_ack = 1'b0; m_cyc[g] = 1'b0;
      settle();
      chk("rr_cyc_gap", 64'(wbs_cyc_o), 64'd0);
      tick();
      m_cyc[g] = 1'b1;
    end
    m_cyc = '0; m_stb = '0;
    tick(); tick();

    // Fixed-priority vector table on the second instance
    tbl.push_back('{cyc: 4'b0000, exp_grant: 4'b0000});
    tbl.push_back('{cyc: 4'b1010, exp_grant: 4'b0010});
    tbl.push_back('{cyc: 4'b1010, exp_grant: 4'b0010});
    tbl.push_back('{cyc: 4'b1000, exp_grant: 4'b1000});
    tbl.push_back('{cyc: 4'b1000, exp_grant: 4'b1000});
    tbl.push_back('{cyc: 4'b1001, exp_grant: 4'b1000});
    tbl.push_back('{cyc: 4'b0001, exp_grant: 4'b0001});
    tbl.push_back('{cyc: 4'b0011, exp_grant: 4'b0001});
    tbl.push_back('{cyc: 4'b0010, exp_grant: 4'b0010});
    tbl.push_back('{cyc: 4'b0000, exp_grant: 4'b0000});
    tbl.push_back('{cyc: 4'b1110, exp_grant: 4'b0010});
    tbl.push_back('{cyc: 4'b0000, exp_grant: 4'b0000});
    for (int i = 0; i < tbl.size(); i++) begin
      p_cyc = tbl[i].cyc;
      tick();
      chk($sformatf("fix_row%0d", i), 64'(p_grant), 64'(tbl[i].exp_grant));
    end
    p_cyc = '0;

    // 8-beat incrementing burst on master 2 must not be split by master 0
    pulse_reset();
    m_cyc = 4'b0100; m_stb = 4'b0100; m_cti[2*3 +: 3] = 3'b010;
    tick();
    chk("burst_grant", 64'(grant_o), 64'b0100);
    m_cyc = 4'b0101; m_stb = 4'b0101;
    for (int b = 0; b < 8; b++) begin
      m_cti[2*3 +: 3] = (b == 7) ? 3'b111 : 3'b010;
      s_ack = 1'b1;
      settle();
      chk("burst_hold", 64'(grant_o), 64'b0100);
      chk("burst_ack", 64'(wbm_ack_o), 64'b0100);
      chk("burst_cti", 64'(wbs_cti_o), (b == 7) ? 64'd7 : 64'd2);
      tick();
    end
    s_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_cti = '0;
    settle();
    tick();
    chk("burst_handover", 64'(grant_o), 64'b0001);

    // Reset while master 1 is mid-transfer
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick();
    chk("rst_mid_grant", 64'(grant_o), 64'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_cyc", 64'(wbs_cyc_o), 64'd0);
    chk("rst_mid_grant0", 64'(grant_o), 64'd0);
    s_ack = 1'b1;
    settle();
    chk("rst_mid_noack", 64'(wbm_ack_o), 64'd0);
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    tick(); tick();

`ifdef WB_ARBITER_RR_WATCHDOG_EN
    // Unresponsive slave: error pulse after 16 stalled cycles, grant passes on
    pulse_reset();
    m_cyc = 4'b0011; m_stb = 4'b0011;
    tick();
    chk("wd_grant", 64'(grant_o), 64'b0001);
    for (int c = 0; c < 16; c++) begin
      settle();
      chk("wd_no_err_yet", 64'(wbm_err_o), 64'd0);
      tick();
    end
    settle();
    chk("wd_err_pulse", 64'(wbm_err_o), 64'b0001);
    chk("wd_cyc_forced", 64'(wbs_cyc_o), 64'd0);
    chk("wd_stb_forced", 64'(wbs_stb_o), 64'd0);
    tick();
    chk("wd_next_grant", 64'(grant_o), 64'b0010);
    chk("wd_err_once", 64'(wbm_err_o), 64'd0);
    m_cyc = '0; m_stb = '0;
    tick(); tick();
`endif

    // Randomized traffic against the round-robin model
    pulse_reset();
    g = -1;
    last = N - 1;
    since_resp = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (i == g) m_cyc[i] = ($urandom_range(3) != 0);
        else        m_cyc[i] = ($urandom_range(1) != 0);
        m_stb[i] = ($urandom_range(1) != 0);
      end
      s_ack = ($urandom_range(1) != 0);
      s_err = ($urandom_range(7) == 0);
      since_resp++;
      if (since_resp >= 8) s_ack = 1'b1;
      if (s_ack || s_err) since_resp = 0;
      settle();
      chk("rand_grant", 64'(grant_o), 64'(onehot(g)));
      chk("rand_cyc", 64'(wbs_cyc_o), 64'((g >= 0) && m_cyc[g]));
      chk("rand_ack", 64'(wbm_ack_o), s_ack ? 64'(onehot(g)) : 64'd0);
      chk("rand_err", 64'(wbm_err_o), s_err ? 64'(onehot(g)) : 64'd0);
      if (g >= 0) chk("rand_adr", 64'(wbs_adr_o), 64'(32'h1000_0000 + 32'(g) * 32'h100));
      tick();
      if (g < 0) begin
        nxt = rr_pick(m_cyc, last);
        if (nxt >= 0) begin g = nxt; last = nxt; end
      end else if (!m_cyc[g]) begin
        req = m_cyc;
        req[g] = 1'b0;
        nxt = rr_pick(req, last);
        g = nxt;
        if (nxt >= 0) last = nxt;
      end
    end
    m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_rr.md
Name: wb_arbiter_rr

Overview:
- Parametrised N-master to 1-slave Wishbone classic/registered-feedback arbiter; the next generation of the existing two-policy arbiter.
- Adds selectable fair round-robin or fixed priority, locking of the grant across bursts and multi-cycle cyc, and zero-dead-cycle handover.
- Sits between CPU/DMA masters and a wb_mux-fronted slave bus.
- Runs in a single clock domain; crossings use wb_cdc.

Parameters:
- dw, 32, data width in bits (multiple of 8).
- aw, 32, address width in bits.
- num_masters, 4, number of masters (2..16).
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT, 255, watchdog limit in cycles; used only with the optional feature; ≥2.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wbm_adr_i  in  num_masters*aw  master addresses, master i in slice [i*aw +: aw]
- wbm_dat_i  in  num_masters*dw  master write data
- wbm_sel_i  in  num_masters*dw/8  byte selects
- wbm_we_i  in  num_masters  write enables
- wbm_cyc_i  in  num_masters  cycle requests
- wbm_stb_i  in  num_masters  strobes
- wbm_cti_i  in  num_masters*3  cycle type
- wbm_bte_i  in  num_masters*2  burst type
- wbm_dat_o  out  num_masters*dw  read data, wbs_dat_i broadcast to all slices
- wbm_ack_o  out  num_masters  ack, granted master only
- wbm_err_o  out  num_masters  err, granted master only
- wbm_rty_o  out  num_masters  rty, granted master only
- wbs_adr_o  out  aw; wbs_dat_o  out  dw; wbs_sel_o  out  dw/8; wbs_we_o  out  1; wbs_cti_o  out  3; wbs_bte_o  out  2: granted master's signals
- wbs_cyc_o  out  1  granted master's cyc while grant valid
- wbs_stb_o  out  1  granted master's stb while grant valid
- wbs_dat_i  in  dw  slave read data
- wbs_ack_i  in  1  slave ack
- wbs_err_i  in  1  slave err
- wbs_rty_i  in  1  slave rty
- grant_o  out  num_masters  one-hot current grant (zero when idle)

Behaviour:
- Clock and reset: single clock wb_clk_i; wb_rst_i is synchronous, active-high.
- Reset values:
  - grant = 0, state IDLE, last_grant = num_masters-1, so master 0 wins first in RR mode.
  - All wbs_* controls and all wbm ack/err/rty are 0 while grant is 0.
- State IDLE:
  - If any wbm_cyc_i is high, register the winner → GRANTED on the next edge.
  - Arbitration latency is one cycle from cyc to wbs_cyc_o.
- Winner selection:
  - RR: first requester scanning from last_grant+1 upward, modulo num_masters.
  - Fixed: lowest-index requester.
- State GRANTED:
  - wbs_* outputs and the granted master's ack/err/rty form a combinational mux/demux on the registered grant.
  - Grant is held while the granted master's cyc stays high, regardless of stb gaps or cti; incrementing/classic bursts are never split.
- Release:
  - Granted cyc observed low at an edge: in the same edge, re-arbitrate among the other requesters and load the new grant (zero dead cycles).
  - If there are no other requesters → IDLE, grant = 0.
  - last_grant is updated on every new grant.
- Simultaneous requests:
  - Resolved only at grant points; requests arriving mid-grant wait.
  - In RR mode, a continuously requesting master waits at most num_masters-1 tenures.
- Non-granted masters: ack/err/rty held 0; their wbm_dat_o still shows wbs_dat_i (ignored).
- wb_rst_i mid-transfer: grant is cleared at that edge, wbs_cyc_o drops, and the in-flight cycle is abandoned with no ack.
- Slave ack, err and rty are passed through unregistered; the arbiter adds no data latency.

Optional Feature:
- Macro: WB_ARBITER_RR_WATCHDOG_EN.
- With the macro:
  - A counter resets on grant and on every slave ack/err/rty.
  - It increments while wbs_stb_o is high without a response.
  - When it reaches TIMEOUT, wbm_err_o pulses for 1 cycle to the granted master and wbs_cyc_o/wbs_stb_o are forced 0 that cycle.
  - The grant is then released and re-arbitrated next edge, as if cyc had dropped.
- Without the macro: no counter logic; an unresponsive slave holds the grant indefinitely.

Test Plan:
- Reset, then master 0 single read (slave acks after 2 cycles, data 0xDEADBEEF) → wbs_cyc_o rises 1 cycle after wbm_cyc_i[0]; wbm_ack_o[0] pulses with wbm_dat_o slice 0 = 0xDEADBEEF; grant_o returns to 0.
- RR mode, all 4 masters hold cyc and do 1 access each, repeated 8 times → grant order 0,1,2,3,0,1,... with no idle cycle between tenures.
- PRIO_MODE=1, masters 1 and 3 request together → master 1 granted; master 3 granted only after master 1 drops cyc.
- Master 2 runs an 8-beat incrementing burst (cti=010, last cti=111) while master 0 requests → burst completes with no intervening grant; master 0 granted on the edge master 2 drops cyc.
- wb_rst_i asserted for 1 cycle while master 1 is mid-transfer → wbs_cyc_o = 0 and grant_o = 0 on the next cycle; no ack reaches master 1.
- With WB_ARBITER_RR_WATCHDOG_EN and TIMEOUT=16, the slave never acks → wbm_err_o[granted] pulses once after 16 stalled cycles, and the grant passes to the next requester.
